sram_mem_controller: RTL and testbench

Multi-cycle controller that sequences the MEM stage's 32-bit data accesses onto an external 16-bit-wide SRAM. It sits between the EXE stage register outputs (address, Val_Rm, mem read/write enables) and the SRAM pins. It drives `ready` low to freeze the pipeline until each access completes. Every 32-bit word is transferred as two 16-bit halves, low half first, each held for a programmable number of wait cycles.

---
 rtl/sram_mem_controller_if.sv | 27 ++
 rtl/sram_mem_controller.sv | 143 ++++++++++++++
 tb/tb_sram_mem_controller.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sram_mem_controller_if.sv
// sram_mem_controller_if: bundles the MEM-stage request/response signals and the external
// 16-bit SRAM pins seen by sram_mem_controller.
//   master : pipeline + SRAM side (drives requests and SRAM read data)
//   slave  : the controller (drives load data, ready and the SRAM pins)
interface sram_mem_controller_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  modport master (
    output rd_en, wr_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  modport slave (
    input  rd_en, wr_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/sram_mem_controller.sv
// sram_mem_controller: sequences 32-bit MEM-stage loads/stores onto a 16-bit external SRAM.
// Each word moves as two halves (low half first), each driven for WAIT_CYCLES cycles; ready is
// held low to freeze the pipeline until the access reaches its DONE cycle.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - sram_mem_controller_if.slave: rd_en/wr_en/address/write_data in, read_data/ready
//          out, plus SRAM pins sram_addr/sram_dq_out/sram_dq_in/sram_dq_oe/sram_we_n
//
// Optional feature: define SRAM_CTRL_BOUNDS_EN to treat offsets >= 2^19 from BASE_ADDR as
// out of range (no SRAM strobes, straight to DONE, reads return 0). Without it, addresses
// alias into the SRAM.
module sram_mem_controller #(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input logic                  clk,
  input logic                  rst,
  sram_mem_controller_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(WAIT_CYCLES) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            is_wr_q, is_wr_d;
  logic [16:0]     word_q, word_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [17:0]     addr_hold_q;
  logic [15:0]     dq_hold_q;

  logic        req;
  logic        phase_last;
  logic [31:0] off;
  logic        strobing;
  logic        half;

  assign req        = bus.rd_en | bus.wr_en;
  assign off        = bus.address - BASE_ADDR;
  assign phase_last = (cnt_q == CntLast);

  // Byte-lane bits never reach the SRAM; upper bits only matter for the range check.
  logic unused_off;
  assign unused_off = ^{off[31:19], off[1:0]};

`ifdef SRAM_CTRL_BOUNDS_EN
  logic out_of_range;
  assign out_of_range = |off[31:19];
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
      word_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      addr_hold_q <= '0;
      dq_hold_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_wr_q     <= is_wr_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      // Capturing the pins every cycle lets IDLE/DONE keep showing the last driven values.
      addr_hold_q <= bus.sram_addr;
      dq_hold_q   <= bus.sram_dq_out;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          // Write wins when both enables are high.
          is_wr_d = bus.wr_en;
          word_d  = off[18:2];
          wdata_d = bus.write_data;
          cnt_d   = '0;
`ifdef SRAM_CTRL_BOUNDS_EN
          if (out_of_range) begin
            state_d = StDone;
            if (!bus.wr_en) rdata_d = '0;
          end else begin
            state_d = StLow;
          end
`else
          state_d = StLow;
`endif
        end
      end
      StLow: begin
        if (phase_last) begin
          cnt_d   = '0;
          state_d = StHigh;
          if (!is_wr_q) rdata_d[15:0] = bus.sram_dq_in;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHigh: begin
        if (phase_last) begin
          cnt_d   = '0;
          state_d = StDone;
          if (!is_wr_q) rdata_d[31:16] = bus.sram_dq_in;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs; strobes decode straight from state so reset deasserts them immediately.
  always_comb begin
    strobing        = (state_q == StLow) || (state_q == StHigh);
    half            = (state_q == StHigh);
    bus.sram_addr   = strobing ? {word_q, half} : addr_hold_q;
    bus.sram_dq_out = strobing ? (half ? wdata_q[31:16] : wdata_q[15:0]) : dq_hold_q;
    bus.sram_dq_oe  = strobing & is_wr_q;
    bus.sram_we_n   = ~(strobing & is_wr_q);
    bus.read_data   = rdata_q;
    bus.ready       = ~req | (state_q == StDone);
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
module tb_sram_mem_controller;
  localparam int          W    = 3;
  localparam logic [31:0] Base = 32'd1024;

  logic clk;
  logic rst;
  sram_mem_controller_if bus ();

  sram_mem_controller #(
    .WAIT_CYCLES (W),
    .BASE_ADDR   (Base)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model with a preload port so only one process writes the array.
  logic [15:0] mem [0:262143];
  logic        pl_en;
  logic [17:0] pl_addr;
  logic [15:0] pl_data;
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (!bus.sram_we_n) mem[bus.sram_addr] <= bus.sram_dq_out;
  end
  assign bus.sram_dq_in = mem[bus.sram_addr];

  int total;
  int bad;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;
  logic [17:0] last_addr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic preload(input logic [17:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    @(posedge clk); #1;
    bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  // Drives one request from the cycle after the next edge and checks every cycle until ready.
  task automatic run_access(input bit do_rd, input bit do_wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rd_exp, input bit oor);
    logic [31:0] off;
    logic [17:0] exp_addr;
    int exp_lat;
    int k;
    bit strobe;
    bit high;
    bit wr;
    off     = addr - Base;
    exp_lat = oor ? 1 : 2 * W + 1;
    wr      = do_wr;
    if (do_rd && !do_wr) exp_q.push_back(oor ? 32'h0 : rd_exp);
    else exp_q.push_back(last_rd);
    @(posedge clk); #1;
    bus.rd_en = do_rd; bus.wr_en = do_wr; bus.address = addr; bus.write_data = wdata;
    #1;
    k = 0;
    forever begin
      strobe   = !oor && (k >= 1) && (k <= 2 * W);
      high     = strobe && (k > W);
      exp_addr = strobe ? {off[18:2], high} : last_addr;
      check_eq("ready", 32'(bus.ready), 32'(k == exp_lat));
      check_eq("we_n", 32'(bus.sram_we_n), 32'(!(strobe && wr)));
      check_eq("dq_oe", 32'(bus.sram_dq_oe), 32'(strobe && wr));
      check_eq("sram_addr", 32'(bus.sram_addr), 32'(exp_addr));
      if (strobe && wr)
        check_eq("dq_out", 32'(bus.sram_dq_out), 32'(high ? wdata[31:16] : wdata[15:0]));
      if (strobe) last_addr = exp_addr;
      if (bus.ready || k >= exp_lat + 4) break;
      if (k == 1) bus.write_data = ~wdata;
      @(posedge clk); #2;
      k++;
    end
    check_eq("latency", 32'(k), 32'(exp_lat));
    if (exp_q.size() > 0) begin
      last_rd = exp_q.pop_front();
      check_eq("read_data", bus.read_data, last_rd);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    total = 0; bad = 0;
    last_rd = '0; last_addr = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.address = '0; bus.write_data = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #2;
    check_eq("rst_ready", 32'(bus.ready), 32'd1);
    check_eq("rst_we_n", 32'(bus.sram_we_n), 32'd1);
    check_eq("rst_oe", 32'(bus.sram_dq_oe), 32'd0);
    check_eq("rst_addr", 32'(bus.sram_addr), 32'd0);
    check_eq("rst_dq", 32'(bus.sram_dq_out), 32'd0);
    check_eq("rst_rdata", bus.read_data, 32'd0);

    // Store then check the halves landed in the model.
    run_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h0, 1'b0);
    check_eq("mem0", 32'(mem[0]), 32'h0000BEEF);
    check_eq("mem1", 32'(mem[1]), 32'h0000DEAD);
    idle_cycles(1);

    preload(18'd3, 16'h1234);
    preload(18'd2, 16'h5678);
    run_access(1'b1, 1'b0, 32'd1028, 32'h0, 32'h12345678, 1'b0);
    idle_cycles(1);

    // Both enables: acts as a write, read_data untouched.
    run_access(1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, 32'h0, 1'b0);
    check_eq("both_mem4", 32'(mem[4]), 32'h00005A5A);
    check_eq("both_mem5", 32'(mem[5]), 32'h0000A5A5);
    idle_cycles(1);

    // Reset in the HIGH phase of a write.
    @(posedge clk); #1;
    bus.wr_en = 1'b1; bus.address = 32'd1024; bus.write_data = 32'h11112222;
    repeat (W + 1) @(posedge clk);
    #2;
    check_eq("pre_rst_we_n", 32'(bus.sram_we_n), 32'd0);
    #1 rst = 1'b0;
    #1;
    check_eq("async_we_n", 32'(bus.sram_we_n), 32'd1);
    check_eq("async_oe", 32'(bus.sram_dq_oe), 32'd0);
    bus.wr_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #2;
    check_eq("post_rst_ready", 32'(bus.ready), 32'd1);
    check_eq("post_rst_we_n", 32'(bus.sram_we_n), 32'd1);
    check_eq("post_rst_rdata", bus.read_data, 32'd0);
    check_eq("post_rst_addr", 32'(bus.sram_addr), 32'd0);
    last_rd = '0; last_addr = '0;

    // Back-to-back write then read with no gap.
    run_access(1'b0, 1'b1, 32'd1024, 32'hCAFEF00D, 32'h0, 1'b0);
    run_access(1'b1, 1'b0, 32'd1024, 32'h0, 32'hCAFEF00D, 1'b0);
    idle_cycles(1);

`ifdef SRAM_CTRL_BOUNDS_EN
    run_access(1'b1, 1'b0, 32'd1020, 32'h0, 32'h0, 1'b1);
`else
    // Offset -4 aliases to the top SRAM word.
    preload(18'h3fffe, 16'h0BAD);
    preload(18'h3ffff, 16'hF00D);
    run_access(1'b1, 1'b0, 32'd1020, 32'h0, 32'hF00D0BAD, 1'b0);
`endif
    idle_cycles(1);

    for (int i = 0; i < 4; i++) begin
      a = Base + 32'(4 * $urandom_range(8, 200));
      d = $urandom;
      run_access(1'b0, 1'b1, a, d, 32'h0, 1'b0);
      run_access(1'b1, 1'b0, a, 32'h0, d, 1'b0);
    end
    idle_cycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
